prediction_filter: RTL and testbench
====================================

PREDICTION_FILTER -- requirements
Module: prediction_filter

Interface
REQ-001 SHALL have parameter PROB_W, default 16, bit width of each probability word.
REQ-002 SHALL have parameter STABLE_COUNT, default 4, number of consecutive equal results needed to update the stable digit (range 1..15).
REQ-003 SHALL have parameter MIN_PROB, default 16'h4000, confidence floor, used only when the macro in REQ-024 is defined.
REQ-004 SHALL have port Clk, input, 1, the single clock.
REQ-005 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port Start, input, 1, new probability vector valid; sampled only in IDLE.
REQ-007 SHALL have port Probability, input, unpacked [9:0] of PROB_W, unsigned class scores, index = digit.
REQ-008 SHALL have port Busy, output, 1, high while not in IDLE.
REQ-009 SHALL have port Done, output, 1, one-cycle pulse when a result is committed.
REQ-010 SHALL have port Argmax, output, 4, digit of the latest committed result.
REQ-011 SHALL have port Max_Prob, output, PROB_W, score of that digit.
REQ-012 SHALL have port Stable_Digit, output, 4, debounced digit for the HEX display.
REQ-013 SHALL have port Stable_Valid, output, 1, high once any digit has become stable.
REQ-014 SHALL have port Low_Conf, output, 1, latest committed Max_Prob is below MIN_PROB.

Function
REQ-015 SHALL implement FSM IDLE -> SCAN -> COMMIT -> IDLE; IDLE -> SCAN on Start=1; SCAN -> COMMIT after index 9; COMMIT -> IDLE unconditionally.
REQ-016 SHALL, on accepting Start, snapshot all 10 Probability words into internal registers and initialise best_idx=0, best_val=snapshot[0], scan index=1; later input changes SHALL NOT affect the result.
REQ-017 SHALL compare one index per cycle in SCAN (indices 1..9, 9 cycles), replacing best only on strictly greater unsigned value, so ties keep the lowest index.
REQ-018 SHALL have fixed latency: Start high in cycle 0 -> Busy high in cycles 1..10 -> Done high in cycle 11 only, with Argmax, Max_Prob, Low_Conf and the stability outputs updated in cycle 11; a Start in cycle 11 SHALL be accepted.
REQ-019 SHALL ignore Start while Busy=1 (no queueing, no effect).
REQ-020 SHALL keep a candidate digit and a counter saturating at STABLE_COUNT; at commit, same digit -> counter+1, different digit -> candidate=new digit and counter=1.
REQ-021 SHALL, at the commit where the counter reaches STABLE_COUNT, load Stable_Digit=candidate and set Stable_Valid=1; Stable_Digit SHALL hold until another candidate reaches STABLE_COUNT.
REQ-022 SHALL, with STABLE_COUNT=1, update Stable_Digit on every commit.

Reset
REQ-023 SHALL, when Reset=1 at a Clk edge (including mid-SCAN), enter IDLE, drop any partial result without a Done pulse, and clear Busy, Done, Argmax, Max_Prob, Stable_Digit, Stable_Valid, Low_Conf, candidate and counter to 0; Reset SHALL take priority over Start.

Configuration
REQ-024 SHALL, with PRED_FILTER_THRESH_EN defined, set Low_Conf=(Max_Prob < MIN_PROB) at commit; a low-confidence commit SHALL clear the counter to 0, SHALL NOT change the candidate or Stable_Digit, and SHALL still pulse Done and update Argmax/Max_Prob.
REQ-025 SHALL, without PRED_FILTER_THRESH_EN, tie Low_Conf to 0, exclude the MIN_PROB comparator, and count every commit.

Verification
REQ-026 SHALL cover ordering: Probability[7]=16'h9000, others 16'h1000, Start pulse in cycle 0 -> Busy in cycles 1..10, Done only in cycle 11, Argmax=7, Max_Prob=16'h9000.
REQ-027 SHALL cover ties: Probability[2]=Probability[5]=16'h8000, others 0 -> Argmax=2.
REQ-028 SHALL cover debounce: with STABLE_COUNT=4, apply vectors with argmax 3,3,3,8,3,3,3,3 -> Stable_Valid first rises at the 8th Done, with Stable_Digit=3; Stable_Digit=0 and Stable_Valid=0 before that.
REQ-029 SHALL cover busy and reset: Start re-pulsed in cycle 5 -> exactly one Done; Reset in cycle 6 of a scan -> no Done, all outputs 0, and a new Start in cycle 8 completes normally.
REQ-030 SHALL cover the threshold: with PRED_FILTER_THRESH_EN and MIN_PROB=16'h4000, inputs argmax 1 at 16'h8000 x3, then 16'h3000, then 16'h8000 x4 -> Low_Conf=1 only on the 4th Done, Stable_Digit=1 only at the 8th Done; without the macro, Stable_Digit=1 at the 4th Done.

Source files
------------

// File: rtl/prediction_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prediction_filter                                                        |
// | Sequential argmax over 10 class scores with a debounced display digit.   |
// | Optional: define PRED_FILTER_THRESH_EN to enable the MIN_PROB floor.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module prediction_filter #(
  parameter int                PROB_W       = 16,
  parameter int                STABLE_COUNT = 4,
  parameter logic [PROB_W-1:0] MIN_PROB     = 16'h4000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [PROB_W-1:0] Probability [9:0],
  output logic              Busy,
  output logic              Done,
  output logic [3:0]        Argmax,
  output logic [PROB_W-1:0] Max_Prob,
  output logic [3:0]        Stable_Digit,
  output logic              Stable_Valid,
  output logic              Low_Conf
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [3:0] c_stable   = 4'(STABLE_COUNT);
  localparam logic [3:0] c_last_idx = 4'd9;

  if (STABLE_COUNT < 1 || STABLE_COUNT > 15 || $bits(MIN_PROB) != PROB_W) begin : g_param_check
    $error("prediction_filter: STABLE_COUNT must be 1..15");
  end

  logic [1:0]        state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        best_idx_q, best_idx_d;
  logic [PROB_W-1:0] best_val_q, best_val_d;
  logic [PROB_W-1:0] snap_q [9:0];
  logic              done_q, done_d;
  logic [3:0]        argmax_q, argmax_d;
  logic [PROB_W-1:0] max_prob_q, max_prob_d;
  logic [3:0]        cand_q, cand_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        stable_q, stable_d;
  logic              stable_valid_q, stable_valid_d;
  logic              low_conf_q, low_conf_d;
  logic              w_low_conf;

`ifdef PRED_FILTER_THRESH_EN
  assign w_low_conf = (best_val_q < MIN_PROB);
`else
  assign w_low_conf = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    best_idx_d     = best_idx_q;
    best_val_d     = best_val_q;
    done_d         = 1'b0;
    argmax_d       = argmax_q;
    max_prob_d     = max_prob_q;
    cand_d         = cand_q;
    cnt_d          = cnt_q;
    stable_d       = stable_q;
    stable_valid_d = stable_valid_q;
    low_conf_d     = low_conf_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d    = ST_SCAN;
          idx_d      = 4'd1;
          best_idx_d = 4'd0;
          best_val_d = Probability[0];
        end
      end
      ST_SCAN: begin
        // Strictly greater only, so ties keep the lowest index
        if (snap_q[idx_q] > best_val_q) begin
          best_idx_d = idx_q;
          best_val_d = snap_q[idx_q];
        end
        if (idx_q == c_last_idx) begin
          state_d = ST_COMMIT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_COMMIT: begin
        state_d    = ST_IDLE;
        done_d     = 1'b1;
        argmax_d   = best_idx_q;
        max_prob_d = best_val_q;
        low_conf_d = w_low_conf;
        if (w_low_conf) begin
          cnt_d = 4'd0;
        end else begin
          if (best_idx_q == cand_q) begin
            if (cnt_q != c_stable) begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cand_d = best_idx_q;
            cnt_d  = 4'd1;
          end
          if (cnt_d == c_stable) begin
            stable_d       = cand_d;
            stable_valid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= 4'd0;
      best_idx_q     <= 4'd0;
      best_val_q     <= '0;
      done_q         <= 1'b0;
      argmax_q       <= 4'd0;
      max_prob_q     <= '0;
      cand_q         <= 4'd0;
      cnt_q          <= 4'd0;
      stable_q       <= 4'd0;
      stable_valid_q <= 1'b0;
      low_conf_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      best_idx_q     <= best_idx_d;
      best_val_q     <= best_val_d;
      done_q         <= done_d;
      argmax_q       <= argmax_d;
      max_prob_q     <= max_prob_d;
      cand_q         <= cand_d;
      cnt_q          <= cnt_d;
      stable_q       <= stable_d;
      stable_valid_q <= stable_valid_d;
      low_conf_q     <= low_conf_d;
    end
  end

  // Score snapshot is pure datapath; it is only read while a scan is live
  always_ff @(posedge Clk) begin
    if (state_q == ST_IDLE && Start) begin
      snap_q <= Probability;
    end
  end

  assign Busy         = (state_q != ST_IDLE);
  assign Done         = done_q;
  assign Argmax       = argmax_q;
  assign Max_Prob     = max_prob_q;
  assign Stable_Digit = stable_q;
  assign Stable_Valid = stable_valid_q;
  assign Low_Conf     = low_conf_q;

endmodule
`default_nettype wire

// File: tb/tb_prediction_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_prediction_filter                                                     |
// | Self-checking bench: vector table, corner sequences, random vs. model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_prediction_filter;

`ifdef PRED_FILTER_THRESH_EN
  localparam bit c_thresh = 1'b1;
`else
  localparam bit c_thresh = 1'b0;
`endif
  localparam logic [15:0] c_min_p = 16'h4000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [15:0] Probability [9:0];

  logic        a_busy, a_done, a_sval, a_low;
  logic [3:0]  a_arg, a_sdig;
  logic [15:0] a_max;
  logic        b_busy, b_done, b_sval, b_low;
  logic [3:0]  b_arg, b_sdig;
  logic [15:0] b_max;

  always #5 Clk = ~Clk;

  prediction_filter #(.PROB_W(16), .STABLE_COUNT(4), .MIN_PROB(c_min_p)) dut_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Probability(Probability),
    .Busy(a_busy), .Done(a_done), .Argmax(a_arg), .Max_Prob(a_max),
    .Stable_Digit(a_sdig), .Stable_Valid(a_sval), .Low_Conf(a_low)
  );

  prediction_filter #(.PROB_W(16), .STABLE_COUNT(1), .MIN_PROB(c_min_p)) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Probability(Probability),
    .Busy(b_busy), .Done(b_done), .Argmax(b_arg), .Max_Prob(b_max),
    .Stable_Digit(b_sdig), .Stable_Valid(b_sval), .Low_Conf(b_low)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: run length of the latest confident digit
  logic [15:0] m_snap [9:0];
  int          m_run;
  logic [3:0]  m_last, m_arg, m_stable4, m_stable1;
  logic [15:0] m_max;
  bit          m_low, m_valid4, m_valid1;

  typedef struct {
    logic [15:0] base;
    int          ia;
    logic [15:0] va;
    int          ib;
    logic [15:0] vb;
    logic [3:0]  exp_arg;
    logic [15:0] exp_max;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    m_run = 0; m_last = 4'd0; m_arg = 4'd0; m_max = 16'h0;
    m_low = 1'b0; m_stable4 = 4'd0; m_stable1 = 4'd0; m_valid4 = 1'b0; m_valid1 = 1'b0;
  endtask

  task automatic model_commit();
    logic [15:0] mx;
    mx = 16'h0;
    for (int i = 0; i < 10; i++) if (m_snap[i] > mx) mx = m_snap[i];
    for (int i = 9; i >= 0; i--) if (m_snap[i] == mx) m_arg = 4'(i);
    m_max = mx;
    m_low = c_thresh && (mx < c_min_p);
    if (m_low) begin
      m_run = 0;
    end else begin
      if (m_run > 0 && m_arg == m_last) m_run++;
      else begin
        m_last = m_arg;
        m_run  = 1;
      end
      if (m_run >= 4) begin
        m_stable4 = m_last;
        m_valid4  = 1'b1;
      end
      m_stable1 = m_last;
      m_valid1  = 1'b1;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, a_busy, 0);
    check({tag, "_done"}, a_done, 0);
    check({tag, "_argmax"}, a_arg, 0);
    check({tag, "_maxprob"}, a_max, 0);
    check({tag, "_sdigit"}, a_sdig, 0);
    check({tag, "_svalid"}, a_sval, 0);
    check({tag, "_lowconf"}, a_low, 0);
    check({tag, "_b_sdigit"}, b_sdig, 0);
    check({tag, "_b_svalid"}, b_sval, 0);
  endtask

  task automatic check_model();
    check("argmax", a_arg, m_arg);
    check("maxprob", a_max, m_max);
    check("lowconf", a_low, m_low);
    check("stable_digit", a_sdig, m_stable4);
    check("stable_valid", a_sval, m_valid4);
    check("b_argmax", b_arg, m_arg);
    check("b_lowconf", b_low, m_low);
    check("b_stable_digit", b_sdig, m_stable1);
    check("b_stable_valid", b_sval, m_valid1);
  endtask

  // Start in the current cycle (cycle 0); optional re-pulse of Start while busy
  task automatic run_one(input int restart_cycle, input bit scramble);
    m_snap = Probability;
    model_commit();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    if (scramble) foreach (Probability[j]) Probability[j] = 16'($urandom);
    for (int c = 1; c <= 10; c++) begin
      check("busy_scan", a_busy, 1);
      check("done_early", a_done, 0);
      check("b_busy_scan", b_busy, 1);
      Start = (c == restart_cycle);
      tick();
      Start = 1'b0;
    end
    check("done_pulse", a_done, 1);
    check("b_done_pulse", b_done, 1);
    check("busy_after", a_busy, 0);
    check_model();
    tick();
    check("done_single", a_done, 0);
    check("busy_idle", a_busy, 0);
  endtask

  initial begin
    int deb [8];
    logic [15:0] thr [8];

    tbl[0] = '{16'h1000,  7, 16'h9000, -1, 16'h0000, 4'd7, 16'h9000};
    tbl[1] = '{16'h0000,  2, 16'h8000,  5, 16'h8000, 4'd2, 16'h8000};
    tbl[2] = '{16'h0000, -1, 16'h0000, -1, 16'h0000, 4'd0, 16'h0000};
    tbl[3] = '{16'hFFFF, -1, 16'h0000, -1, 16'h0000, 4'd0, 16'hFFFF};
    tbl[4] = '{16'h0000,  9, 16'h0001, -1, 16'h0000, 4'd9, 16'h0001};
    tbl[5] = '{16'h0005,  0, 16'hFFFF,  9, 16'hFFFE, 4'd0, 16'hFFFF};
    tbl[6] = '{16'h7FFE,  4, 16'h7FFF,  8, 16'h7FFF, 4'd4, 16'h7FFF};
    tbl[7] = '{16'h3FFF,  6, 16'h4000, -1, 16'h0000, 4'd6, 16'h4000};
    deb = '{3, 3, 3, 8, 3, 3, 3, 3};
    thr = '{16'h8000, 16'h8000, 16'h8000, 16'h3000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};

    Start = 1'b0;
    foreach (Probability[j]) Probability[j] = 16'h0;
    do_reset();
    check_all_zero("reset");

    // Vector table
    for (int i = 0; i < 8; i++) begin
      foreach (Probability[j]) Probability[j] = tbl[i].base;
      if (tbl[i].ia >= 0) Probability[tbl[i].ia] = tbl[i].va;
      if (tbl[i].ib >= 0) Probability[tbl[i].ib] = tbl[i].vb;
      run_one(-1, (i % 2) == 1);
      check("tbl_argmax", a_arg, tbl[i].exp_arg);
      check("tbl_maxprob", a_max, tbl[i].exp_max);
      check("tbl_lowconf", a_low, c_thresh && (tbl[i].exp_max < c_min_p));
    end

    // Debounce 3,3,3,8,3,3,3,3
    do_reset();
    for (int k = 0; k < 8; k++) begin
      foreach (Probability[j]) Probability[j] = 16'h0100;
      Probability[deb[k]] = 16'h8000;
      run_one(-1, 1'b0);
      check("deb_valid", a_sval, k == 7);
      check("deb_digit", a_sdig, (k == 7) ? 3 : 0);
    end

    // Confidence floor sequence
    do_reset();
    for (int k = 0; k < 8; k++) begin
      foreach (Probability[j]) Probability[j] = 16'h0000;
      Probability[1] = thr[k];
      run_one(-1, 1'b0);
      check("thr_lowconf", a_low, c_thresh && (k == 3));
      check("thr_valid", a_sval, c_thresh ? (k == 7) : (k >= 3));
      check("thr_digit", a_sdig, (c_thresh ? (k == 7) : (k >= 3)) ? 1 : 0);
    end

    // Start re-pulsed mid-scan is ignored
    foreach (Probability[j]) Probability[j] = 16'(j * 16'h0800 + 16'h0100);
    run_one(5, 1'b1);

    // Reset in cycle 6 of a scan, then a fresh Start in cycle 8
    foreach (Probability[j]) Probability[j] = 16'h2000;
    Probability[4] = 16'hA000;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (5) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    model_reset();
    check_all_zero("midreset");
    tick();
    check("midreset_no_done", a_done, 0);
    run_one(-1, 1'b0);
    check("after_reset_argmax", a_arg, 4);

    // Reset has priority over Start
    Reset = 1'b1;
    Start = 1'b1;
    tick();
    Reset = 1'b0;
    Start = 1'b0;
    model_reset();
    check("prio_busy", a_busy, 0);
    tick();
    check("prio_busy2", a_busy, 0);
    check("prio_done", a_done, 0);

    // Randomised scans against the reference model
    for (int n = 0; n < 60; n++) begin
      int d;
      int rc;
      if ($urandom_range(0, 1) == 1) begin
        foreach (Probability[j]) Probability[j] = 16'($urandom);
      end else begin
        d = ($urandom_range(0, 3) == 0) ? 5 : 2;
        foreach (Probability[j]) Probability[j] = 16'($urandom_range(0, 32'h2FFF));
        Probability[d] = 16'($urandom_range(32'h3000, 32'h6000));
        if ($urandom_range(0, 3) == 0) Probability[$urandom_range(0, 9)] = Probability[d];
      end
      rc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1;
      run_one(rc, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
